// File: rtl/picorv32_ahb_strobe_bridge_pkg.sv
// Shared definitions for the PicoRV32 -> FreeAHB strobe bridge.
// Contents:
//   state_t            bridge FSM state encoding
//   SIZE_BYTE/HALF/WORD  freeahb_size encodings
//   PROT_*_DEFAULT     default freeahb_prot values for fetches and data
//   replicate_lanes()  copies a beat's bytes across every lane of its size
package picorv32_ahb_strobe_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } state_t;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  localparam logic [3:0] PROT_INSTR_DEFAULT = 4'b0000;
  localparam logic [3:0] PROT_DATA_DEFAULT  = 4'b0001;

  // The slave may pick its byte lanes from either half/any byte, so the
  // selected bytes are copied everywhere rather than left in place.
  function automatic logic [31:0] replicate_lanes(input logic [31:0] data,
                                                  input logic [3:0]  lanes,
                                                  input logic [2:0]  size);
    logic [31:0] r;
    r = data;
    if (size == SIZE_HALF) begin
      r = lanes[0] ? {2{data[15:0]}} : {2{data[31:16]}};
    end else if (size == SIZE_BYTE) begin
      if (lanes[0])      r = {4{data[7:0]}};
      else if (lanes[1]) r = {4{data[15:8]}};
      else if (lanes[2]) r = {4{data[23:16]}};
      else               r = {4{data[31:24]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/picorv32_ahb_strobe_bridge_beat.sv
// picorv32_ahb_beat_planner: purely combinational choice of the next write
// beat from the mask of lanes still to be issued.
// Ports:
//   i_pending  lanes not yet written
//   o_lanes    lanes covered by the chosen beat (0 when nothing pending)
//   o_size     freeahb_size encoding of the beat
//   o_offset   byte offset of the beat within the word
//   o_min_len  beat length in bits (8/16/32)
module picorv32_ahb_beat_planner
  import picorv32_ahb_strobe_bridge_pkg::*;
#(
  parameter bit MERGE_STROBES = 1'b1,
  parameter bit BIG_ENDIAN    = 1'b1
) (
  input  logic [3:0]  i_pending,
  output logic [3:0]  o_lanes,
  output logic [2:0]  o_size,
  output logic [1:0]  o_offset,
  output logic [31:0] o_min_len
);

  function automatic logic [1:0] lane_offset(input logic [1:0] lane);
    return BIG_ENDIAN ? (2'd3 - lane) : lane;
  endfunction

  always_comb begin
    o_lanes   = 4'b0000;
    o_size    = SIZE_BYTE;
    o_offset  = 2'd0;
    o_min_len = 32'd8;
    if (MERGE_STROBES && i_pending == 4'b1111) begin
      o_lanes   = 4'b1111;
      o_size    = SIZE_WORD;
      o_min_len = 32'd32;
    end else if (MERGE_STROBES && i_pending[1:0] == 2'b11) begin
      o_lanes   = 4'b0011;
      o_size    = SIZE_HALF;
      o_offset  = BIG_ENDIAN ? 2'd2 : 2'd0;
      o_min_len = 32'd16;
    end else if (MERGE_STROBES && i_pending[3:2] == 2'b11) begin
      o_lanes   = 4'b1100;
      o_size    = SIZE_HALF;
      o_offset  = BIG_ENDIAN ? 2'd0 : 2'd2;
      o_min_len = 32'd16;
    end else begin
      // Scan downward so the lowest set lane is the one that sticks.
      for (int k = 3; k >= 0; k--) begin
        if (i_pending[k]) begin
          o_lanes  = 4'b0001 << k;
          o_offset = lane_offset(k[1:0]);
        end
      end
    end
  end

endmodule

// File: rtl/picorv32_ahb_strobe_bridge.sv
// picorv32_ahb_strobe_bridge: turns one PicoRV32 native memory request into
// FreeAHB beats. Reads become one word beat; writes are split by strobe
// into byte/halfword/word beats chosen by picorv32_ahb_beat_planner.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   mem_valid/instr/addr/wdata/wstrb PicoRV32 request (wstrb==0 is a read)
//   mem_ready, mem_rdata             completion pulse, registered read data
//   freeahb_valid/write/read         beat request and direction
//   freeahb_addr/wdata/size/prot     beat attributes (held until accepted)
//   freeahb_min_len                  beat length in bits
//   freeahb_cont, freeahb_lock       unused, tied low
//   freeahb_next                     beat accepted this cycle
//   freeahb_ready, freeahb_rdata     read data return
module picorv32_ahb_strobe_bridge
  import picorv32_ahb_strobe_bridge_pkg::*;
#(
  parameter bit         MERGE_STROBES = 1'b1,
  parameter bit         BIG_ENDIAN    = 1'b1,
  parameter logic [3:0] PROT_INSTR    = PROT_INSTR_DEFAULT,
  parameter logic [3:0] PROT_DATA     = PROT_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        freeahb_valid,
  output logic        freeahb_write,
  output logic        freeahb_read,
  output logic [31:0] freeahb_addr,
  output logic [31:0] freeahb_wdata,
  output logic [2:0]  freeahb_size,
  output logic [3:0]  freeahb_prot,
  output logic [31:0] freeahb_min_len,
  output logic        freeahb_cont,
  output logic        freeahb_lock,
  input  logic        freeahb_next,
  input  logic        freeahb_ready,
  input  logic [31:0] freeahb_rdata
);

  state_t      r_state;
  logic [3:0]  r_pending;   // lanes not yet accepted, including the beat on the bus
  logic [3:0]  r_lanes;     // lanes of the beat currently on the bus
  logic [29:0] r_base;
  logic [31:0] r_wdata;
  logic        r_blocked;   // completed; waiting for mem_valid to drop
  logic        r_abort;     // mem_valid fell mid-request
  logic        r_mem_ready;
  logic [31:0] r_mem_rdata;
  logic        r_valid;
  logic        r_write;
  logic        r_read;
  logic [31:0] r_addr;
  logic [31:0] r_bwdata;
  logic [2:0]  r_size;
  logic [3:0]  r_prot;
  logic [31:0] r_min_len;

  logic [3:0]  w_remaining;
  logic [3:0]  w_plan_mask;
  logic [29:0] w_base;
  logic [31:0] w_data;
  logic        w_abort;
  logic [3:0]  w_lanes;
  logic [2:0]  w_size;
  logic [1:0]  w_offset;
  logic [31:0] w_min_len;
  logic        w_unused;

  // In IDLE the first beat is planned straight from the request so it can be
  // registered on the accepting edge; afterwards it comes from what is left.
  assign w_remaining = r_pending & ~r_lanes;
  assign w_plan_mask = (r_state == IDLE) ? mem_wstrb : w_remaining;
  assign w_base      = (r_state == IDLE) ? mem_addr[31:2] : r_base;
  assign w_data      = (r_state == IDLE) ? mem_wdata : r_wdata;
  assign w_abort     = r_abort | ~mem_valid;
  assign w_unused    = ^mem_addr[1:0];

  picorv32_ahb_beat_planner #(
    .MERGE_STROBES(MERGE_STROBES),
    .BIG_ENDIAN   (BIG_ENDIAN)
  ) u_planner (
    .i_pending(w_plan_mask),
    .o_lanes  (w_lanes),
    .o_size   (w_size),
    .o_offset (w_offset),
    .o_min_len(w_min_len)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_pending   <= 4'b0000;
      r_lanes     <= 4'b0000;
      r_base      <= '0;
      r_wdata     <= '0;
      r_blocked   <= 1'b0;
      r_abort     <= 1'b0;
      r_mem_ready <= 1'b0;
      r_mem_rdata <= '0;
      r_valid     <= 1'b0;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_addr      <= '0;
      r_bwdata    <= '0;
      r_size      <= SIZE_WORD;
      r_prot      <= PROT_DATA;
      r_min_len   <= 32'd32;
    end else begin
      r_mem_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_blocked) begin
            if (!mem_valid) r_blocked <= 1'b0;
          end else if (mem_valid) begin
            r_prot  <= mem_instr ? PROT_INSTR : PROT_DATA;
            r_abort <= 1'b0;
            r_valid <= 1'b1;
            if (mem_wstrb == 4'b0000) begin
              r_read    <= 1'b1;
              r_write   <= 1'b0;
              r_addr    <= {mem_addr[31:2], 2'b00};
              r_size    <= SIZE_WORD;
              r_min_len <= 32'd32;
              r_state   <= RD_REQ;
            end else begin
              r_pending <= mem_wstrb;
              r_wdata   <= mem_wdata;
              r_base    <= mem_addr[31:2];
              r_lanes   <= w_lanes;
              r_read    <= 1'b0;
              r_write   <= 1'b1;
              r_addr    <= {w_base, w_offset};
              r_bwdata  <= replicate_lanes(w_data, w_lanes, w_size);
              r_size    <= w_size;
              r_min_len <= w_min_len;
              r_state   <= WR_REQ;
            end
          end
        end
        RD_REQ: begin
          if (!mem_valid) r_abort <= 1'b1;
          if (freeahb_next) begin
            r_valid <= 1'b0;
            r_read  <= 1'b0;
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (!mem_valid) r_abort <= 1'b1;
          if (freeahb_ready) begin
            if (w_abort) begin
              r_state <= IDLE;
            end else begin
              r_mem_rdata <= freeahb_rdata;
              r_mem_ready <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        WR_REQ: begin
          if (!mem_valid) r_abort <= 1'b1;
          if (freeahb_next) begin
            r_pending <= w_remaining;
            if (w_abort || w_remaining == 4'b0000) begin
              r_valid <= 1'b0;
              r_write <= 1'b0;
              r_lanes <= 4'b0000;
              if (w_abort) begin
                r_pending <= 4'b0000;
                r_state   <= IDLE;
              end else begin
                r_mem_ready <= 1'b1;
                r_state     <= DONE;
              end
            end else begin
              r_lanes   <= w_lanes;
              r_addr    <= {w_base, w_offset};
              r_bwdata  <= replicate_lanes(w_data, w_lanes, w_size);
              r_size    <= w_size;
              r_min_len <= w_min_len;
            end
          end
        end
        DONE: begin
          r_blocked <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_ready       = r_mem_ready;
  assign mem_rdata       = r_mem_rdata;
  assign freeahb_valid   = r_valid;
  assign freeahb_write   = r_write;
  assign freeahb_read    = r_read;
  assign freeahb_addr    = r_addr;
  assign freeahb_wdata   = r_bwdata;
  assign freeahb_size    = r_size;
  assign freeahb_prot    = r_prot;
  assign freeahb_min_len = r_min_len;
  assign freeahb_cont    = 1'b0;
  assign freeahb_lock    = 1'b0;

endmodule

// File: tb/tb_picorv32_ahb_strobe_bridge.sv
// Bench for picorv32_ahb_strobe_bridge. Three instances:
//   0: MERGE=1 BIG_ENDIAN=1, 1: MERGE=0 BIG_ENDIAN=1, 2: MERGE=1 BIG_ENDIAN=0
module tb_picorv32_ahb_strobe_bridge;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] min_len;
    logic [3:0]  prot;
    logic        wr;
    logic        rd;
  } beat_t;

  typedef struct {
    int          d;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          stall;
    logic [31:0] rdata;
    int          nbeats;
    logic [31:0] first_addr;
    logic [2:0]  first_size;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] f_rdata = '0;
  logic        mv [3];
  logic        nx [3];
  logic        rdy [3];

  logic        m_ready [3];
  logic [31:0] m_rdata [3];
  logic        f_valid [3];
  logic        f_write [3];
  logic        f_read [3];
  logic [31:0] f_addr [3];
  logic [31:0] f_wdata [3];
  logic [2:0]  f_size [3];
  logic [3:0]  f_prot [3];
  logic [31:0] f_minlen [3];
  logic        f_cont [3];
  logic        f_lock [3];

  int n_checks = 0;
  int n_pass = 0;
  beat_t exp_q[$];
  vec_t vecs[13];
  int cyc, quiet, nb;
  logic [31:0] fa;
  logic [2:0] fs;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    picorv32_ahb_strobe_bridge #(
      .MERGE_STROBES(gi != 1),
      .BIG_ENDIAN   (gi != 2)
    ) u_dut (
      .clk            (clk),
      .resetn         (resetn),
      .mem_valid      (mv[gi]),
      .mem_instr      (mem_instr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_wstrb      (mem_wstrb),
      .mem_ready      (m_ready[gi]),
      .mem_rdata      (m_rdata[gi]),
      .freeahb_valid  (f_valid[gi]),
      .freeahb_write  (f_write[gi]),
      .freeahb_read   (f_read[gi]),
      .freeahb_addr   (f_addr[gi]),
      .freeahb_wdata  (f_wdata[gi]),
      .freeahb_size   (f_size[gi]),
      .freeahb_prot   (f_prot[gi]),
      .freeahb_min_len(f_minlen[gi]),
      .freeahb_cont   (f_cont[gi]),
      .freeahb_lock   (f_lock[gi]),
      .freeahb_next   (nx[gi]),
      .freeahb_ready  (rdy[gi]),
      .freeahb_rdata  (f_rdata)
    );
  end

  task automatic check(input string name, input bit ok, input string act, input string exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  function automatic string bstr(input beat_t b);
    return $sformatf("a=%h w=%h s=%0d len=%0d p=%h wr=%b rd=%b",
                     b.addr, b.wdata, b.size, b.min_len, b.prot, b.wr, b.rd);
  endfunction

  function automatic beat_t sample(input int d);
    beat_t b;
    b.addr = f_addr[d]; b.wdata = f_wdata[d]; b.size = f_size[d];
    b.min_len = f_minlen[d]; b.prot = f_prot[d]; b.wr = f_write[d]; b.rd = f_read[d];
    return b;
  endfunction

  // Reference: a group of n bytes starting at lane lo sits at offset lo
  // (little endian) or 4-lo-n (big endian); its bytes repeat every n lanes.
  function automatic void model_push(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [3:0] wstrb, input logic instr);
    beat_t b;
    logic [3:0] mask;
    int lo, n;
    bit merge, be;
    merge = (d != 1);
    be = (d != 2);
    b = '0;
    b.prot = instr ? 4'h0 : 4'h1;
    if (wstrb == 4'b0000) begin
      b.addr = {addr[31:2], 2'b00}; b.size = 3'd2; b.min_len = 32; b.rd = 1'b1;
      exp_q.push_back(b);
      return;
    end
    b.wr = 1'b1;
    mask = wstrb;
    while (mask != 4'b0000) begin
      lo = 0;
      while (!mask[lo]) lo++;
      n = 1;
      if (merge && mask == 4'hF) n = 4;
      else if (merge && mask[1:0] == 2'b11) begin lo = 0; n = 2; end
      else if (merge && mask[3:2] == 2'b11) begin lo = 2; n = 2; end
      b.addr = {addr[31:2], 2'b00} + 32'(be ? 4 - lo - n : lo);
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wdata[8*(lo + i % n) +: 8];
      b.size = (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
      b.min_len = 32'(8 * n);
      for (int i = lo; i < lo + n; i++) mask[i] = 1'b0;
      exp_q.push_back(b);
    end
  endfunction

  task automatic run_txn(input int d, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input int stall,
                         input logic [31:0] rdata, output int nbeats,
                         output logic [31:0] first_addr, output logic [2:0] first_size);
    beat_t got, cur, exp_b;
    int wait_cnt, cycles, nready, rd_cd, excl_bad, late;
    bit stable;
    wait_cnt = 0; cycles = 0; nready = 0; rd_cd = 0; excl_bad = 0; late = 0;
    nbeats = 0; stable = 1'b1; first_addr = '0; first_size = '0; got = '0;
    exp_q.delete();
    model_push(d, addr, wdata, wstrb, instr);
    @(negedge clk);
    mem_instr = instr; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mv[d] = 1'b1;
    while (nready == 0 && cycles < 300) begin
      @(negedge clk);
      cycles++;
      nx[d] = 1'b0; rdy[d] = 1'b0;
      if (f_read[d] && f_write[d]) excl_bad++;
      if (m_ready[d]) begin
        nready = 1;
        if (wstrb == 4'b0000)
          check("rdata", m_rdata[d] == rdata, $sformatf("%h", m_rdata[d]), $sformatf("%h", rdata));
      end else if (f_valid[d]) begin
        cur = sample(d);
        if (wait_cnt == 0) got = cur;
        else if (cur != got) stable = 1'b0;
        if (wait_cnt >= stall) begin
          nx[d] = 1'b1;
          if (wait_cnt > 0) check("beat_stable", stable, bstr(cur), bstr(got));
          if (exp_q.size() == 0) begin
            check("extra_beat", 1'b0, bstr(got), "no beat");
          end else begin
            exp_b = exp_q.pop_front();
            check("beat", got.addr == exp_b.addr && got.size == exp_b.size &&
                  got.min_len == exp_b.min_len && got.prot == exp_b.prot &&
                  got.wr == exp_b.wr && got.rd == exp_b.rd && (got.rd || got.wdata == exp_b.wdata),
                  bstr(got), bstr(exp_b));
          end
          nbeats++;
          if (nbeats == 1) begin first_addr = got.addr; first_size = got.size; end
          wait_cnt = 0; stable = 1'b1;
          if (got.rd) rd_cd = 2;
        end else begin
          wait_cnt++;
        end
      end
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin rdy[d] = 1'b1; f_rdata = rdata; end
      end
    end
    nx[d] = 1'b0; rdy[d] = 1'b0;
    check("mem_ready_seen", nready == 1, $sformatf("%0d", nready), "1");
    check("beats_left", exp_q.size() == 0, $sformatf("%0d", exp_q.size()), "0");
    check("rd_wr_excl", excl_bad == 0, $sformatf("%0d", excl_bad), "0");
    // mem_valid still high after completion: nothing new may start
    repeat (2) begin
      @(negedge clk);
      if (f_valid[d] || m_ready[d]) late++;
    end
    check("blocked_after_done", late == 0, $sformatf("%0d", late), "0");
    mv[d] = 1'b0; mem_wstrb = 4'b0000;
    @(negedge clk);
    $display("txn d=%0d instr=%b wstrb=%b addr=%h stall=%0d beats=%0d", d, instr, wstrb, addr, stall, nbeats);
  endtask

  task automatic check_reset(input int d, input string tag);
    check({tag, "_ctrl"}, {f_valid[d], f_write[d], f_read[d], m_ready[d], f_cont[d], f_lock[d]} == 6'b0,
          $sformatf("%b", {f_valid[d], f_write[d], f_read[d], m_ready[d], f_cont[d], f_lock[d]}), "000000");
    check({tag, "_addr_wdata"}, f_addr[d] == 32'h0 && f_wdata[d] == 32'h0,
          $sformatf("%h/%h", f_addr[d], f_wdata[d]), "00000000/00000000");
    check({tag, "_size_len"}, f_size[d] == 3'd2 && f_minlen[d] == 32'd32,
          $sformatf("%0d/%0d", f_size[d], f_minlen[d]), "2/32");
    check({tag, "_prot_rdata"}, f_prot[d] == 4'h1 && m_rdata[d] == 32'h0,
          $sformatf("%h/%h", f_prot[d], m_rdata[d]), "1/00000000");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin mv[i] = 1'b0; nx[i] = 1'b0; rdy[i] = 1'b0; end
    //          d instr addr          wdata         wstrb  stall rdata         n first_addr    size
    vecs[0]  = '{0, 1'b0, 32'h100, 32'h0,        4'b0000, 2, 32'hDEADBEEF, 1, 32'h100, 3'd2};
    vecs[1]  = '{0, 1'b0, 32'h200, 32'h11223344, 4'b1111, 0, 32'h0,        1, 32'h200, 3'd2};
    vecs[2]  = '{0, 1'b0, 32'h300, 32'hA5B6C7D8, 4'b0101, 1, 32'h0,        2, 32'h303, 3'd0};
    vecs[3]  = '{1, 1'b0, 32'h300, 32'h01020304, 4'b1100, 0, 32'h0,        2, 32'h301, 3'd0};
    vecs[4]  = '{0, 1'b0, 32'h300, 32'h01020304, 4'b1100, 0, 32'h0,        1, 32'h300, 3'd1};
    vecs[5]  = '{0, 1'b0, 32'h600, 32'hCAFEF00D, 4'b0011, 0, 32'h0,        1, 32'h602, 3'd1};
    vecs[6]  = '{1, 1'b0, 32'h600, 32'hCAFEF00D, 4'b0011, 1, 32'h0,        2, 32'h603, 3'd0};
    vecs[7]  = '{1, 1'b0, 32'h700, 32'h89ABCDEF, 4'b1111, 0, 32'h0,        4, 32'h703, 3'd0};
    vecs[8]  = '{0, 1'b0, 32'h800, 32'h000000EE, 4'b0001, 0, 32'h0,        1, 32'h803, 3'd0};
    vecs[9]  = '{0, 1'b0, 32'h900, 32'h55AA55AA, 4'b1111, 5, 32'h0,        1, 32'h900, 3'd2};
    vecs[10] = '{2, 1'b0, 32'hA00, 32'h12345678, 4'b0011, 0, 32'h0,        1, 32'hA00, 3'd1};
    vecs[11] = '{2, 1'b1, 32'hB06, 32'h0,        4'b0000, 0, 32'h13579BDF, 1, 32'hB04, 3'd2};
    vecs[12] = '{1, 1'b0, 32'h300, 32'h0F1E2D3C, 4'b0101, 5, 32'h0,        2, 32'h303, 3'd0};

    repeat (2) @(negedge clk);
    check_reset(0, "reset_low");
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_reset(2, "reset_idle");

    foreach (vecs[i]) begin
      run_txn(vecs[i].d, vecs[i].instr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
              vecs[i].stall, vecs[i].rdata, nb, fa, fs);
      check($sformatf("vec%0d_nbeats", i), nb == vecs[i].nbeats, $sformatf("%0d", nb),
            $sformatf("%0d", vecs[i].nbeats));
      check($sformatf("vec%0d_first", i), fa == vecs[i].first_addr && fs == vecs[i].first_size,
            $sformatf("%h/%0d", fa, fs), $sformatf("%h/%0d", vecs[i].first_addr, vecs[i].first_size));
    end

    // mem_valid withdrawn while the first beat of a 2-beat write is stalled
    @(negedge clk);
    mem_instr = 1'b0; mem_addr = 32'h500; mem_wdata = 32'h55667788; mem_wstrb = 4'b0101; mv[0] = 1'b1;
    cyc = 0;
    while (!f_valid[0] && cyc < 20) begin @(negedge clk); cyc++; end
    check("abort_first_beat", f_valid[0] && f_addr[0] == 32'h503,
          $sformatf("%b/%h", f_valid[0], f_addr[0]), "1/00000503");
    mv[0] = 1'b0; mem_wstrb = 4'b0000;
    @(negedge clk);
    check("abort_beat_held", f_valid[0] && f_addr[0] == 32'h503,
          $sformatf("%b/%h", f_valid[0], f_addr[0]), "1/00000503");
    nx[0] = 1'b1;
    @(negedge clk);
    nx[0] = 1'b0;
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      if (f_valid[0] || m_ready[0]) quiet++;
    end
    check("abort_quiet", quiet == 0, $sformatf("%0d", quiet), "0");
    $display("txn d=0 abort wstrb=0101 addr=00000500");

    // reset pulsed during the second beat of a 4-beat write
    @(negedge clk);
    mem_instr = 1'b0; mem_addr = 32'h400; mem_wdata = 32'hA1B2C3D4; mem_wstrb = 4'b1111; mv[1] = 1'b1;
    cyc = 0;
    while (!f_valid[1] && cyc < 20) begin @(negedge clk); cyc++; end
    nx[1] = 1'b1;
    @(negedge clk);
    nx[1] = 1'b0;
    check("second_beat", f_valid[1] && f_addr[1] == 32'h402 && f_wdata[1] == 32'hC3C3C3C3,
          $sformatf("%b/%h/%h", f_valid[1], f_addr[1], f_wdata[1]), "1/00000402/c3c3c3c3");
    #2;
    resetn = 1'b0; mv[1] = 1'b0; mem_wstrb = 4'b0000;
    #1;
    check_reset(1, "reset_mid_beat");
    @(negedge clk);
    resetn = 1'b1;
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (f_valid[1] || m_ready[1]) quiet++;
    end
    check("reset_no_ready", quiet == 0, $sformatf("%0d", quiet), "0");
    $display("txn d=1 reset mid-write wstrb=1111 addr=00000400");
    run_txn(1, 1'b0, 32'h104, 32'h0, 4'b0000, 1, 32'h600DF00D, nb, fa, fs);
    check("post_reset_read", nb == 1 && fa == 32'h104, $sformatf("%0d/%h", nb, fa), "1/00000104");

    for (int i = 0; i < 40; i++) begin
      run_txn($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom, $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom, nb, fa, fs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/picorv32_ahb_strobe_bridge.md
PICORV32_AHB_STROBE_BRIDGE -- requirements
Module: picorv32_ahb_strobe_bridge

Interface
REQ-001 Parameter MERGE_STROBES, default 1, meaning: 1 coalesces aligned contiguous strobe groups into halfword/word beats; 0 issues one byte beat per set strobe.
REQ-002 Parameter BIG_ENDIAN, default 1, meaning: 1 maps strobe lane k to address offset 3-k; 0 maps lane k to offset k.
REQ-003 Parameter PROT_INSTR, default 4'b0000, meaning: freeahb_prot for instruction fetches.
REQ-004 Parameter PROT_DATA, default 4'b0001, meaning: freeahb_prot for data accesses.
REQ-005 Port clk  in  1  clock, rising edge.
REQ-006 Port resetn  in  1  reset, asynchronous, active-low.
REQ-007 Port mem_valid, mem_instr  in  1 each  PicoRV32 request valid, instruction-fetch flag.
REQ-008 Port mem_addr, mem_wdata  in  32 each  request address, write data.
REQ-009 Port mem_wstrb  in  4  byte strobes; 0 = read.
REQ-010 Port mem_ready  out  1  one-cycle completion pulse.
REQ-011 Port mem_rdata  out  32  read data, registered.
REQ-012 Port freeahb_valid, freeahb_write, freeahb_read  out  1 each  beat request and direction.
REQ-013 Port freeahb_addr, freeahb_wdata  out  32 each  beat address, lane-replicated write data.
REQ-014 Port freeahb_size  out  3  0 = byte, 1 = halfword, 2 = word.
REQ-015 Port freeahb_prot  out  4; freeahb_min_len  out  32; freeahb_cont, freeahb_lock  out  1, both tied 0.
REQ-016 Port freeahb_next  in  1  beat accepted this cycle.
REQ-017 Port freeahb_ready, freeahb_rdata  in  1, 32  read data valid, read data.

Function
REQ-018 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
REQ-019 IDLE with mem_valid=1 and wstrb=0 SHALL go to RD_REQ, presenting a word read at mem_addr with 2 LSBs cleared, freeahb_min_len=32.
REQ-020 RD_REQ SHALL hold freeahb_valid=1 until freeahb_next=1, then go to RD_WAIT with freeahb_valid=0.
REQ-021 RD_WAIT SHALL capture freeahb_rdata into mem_rdata on freeahb_ready=1 and go to DONE.
REQ-022 IDLE with mem_valid=1 and wstrb!=0 SHALL latch wstrb into a pending mask, wdata and addr, then go to WR_REQ.
REQ-023 Beat planner (MERGE_STROBES=1): pending 1111 -> one word beat; lanes {1,0} or {3,2} both set -> halfword beat on that pair; otherwise lowest-index remaining single lane -> byte beat.
REQ-024 Beat planner (MERGE_STROBES=0): lowest-index remaining lane -> byte beat.
REQ-025 Beat address = word base + lane offset per BIG_ENDIAN; beat size per REQ-023/024; freeahb_min_len = 8, 16 or 32 to match size.
REQ-026 freeahb_wdata SHALL carry the beat's bytes replicated across all lanes of their size.
REQ-027 WR_REQ SHALL hold all beat outputs stable with freeahb_valid=1, freeahb_write=1 until freeahb_next=1, then clear the issued lanes from the pending mask.
REQ-028 WR_REQ with the pending mask empty after a beat is accepted SHALL go to DONE; the next beat, if any, SHALL be presented the following cycle.
REQ-029 DONE SHALL pulse mem_ready for exactly one cycle, then wait in IDLE-blocked mode until mem_valid=0 before accepting a new request.
REQ-030 freeahb_prot SHALL equal PROT_INSTR if mem_instr was set at latch, else PROT_DATA.
REQ-031 Beat count per write: 1111 -> 1 (merge) or 4; 0011 -> 1 or 2; 0101 -> 2; 0001 -> 1.
REQ-032 mem_valid falling before mem_ready: the bridge SHALL finish any beat already presented, issue no further beats, return to IDLE, and not assert mem_ready.
REQ-033 freeahb_read and freeahb_write SHALL never be 1 simultaneously.

Reset
REQ-034 resetn=0 SHALL immediately force IDLE, pending mask 0, mem_ready=0, freeahb_valid/write/read=0, mem_rdata=0, freeahb_addr/wdata=0, freeahb_size=2, freeahb_min_len=32; prot=PROT_DATA.
REQ-035 Reset mid-beat SHALL abandon the beat with no completion pulse.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, size encodings (BYTE/HALF/WORD) and the default PROT constants.
REQ-037 A combinational sub-module picorv32_ahb_beat_planner (pending mask, MERGE_STROBES, BIG_ENDIAN -> lanes, size, offset, min_len) SHALL be used.

Verification
REQ-038 Read addr 0x100, freeahb_next after 2 cycles, ready with 0xDEADBEEF -> single word read at 0x100; mem_rdata=0xDEADBEEF; one mem_ready pulse.
REQ-039 Write wstrb=1111, MERGE=1, wdata 0x11223344 addr 0x200 -> one word beat at 0x200, size 2; mem_ready once.
REQ-040 Write wstrb=0101, BIG_ENDIAN=1, addr 0x300 -> byte beats at 0x303 then 0x301; size 0 each.
REQ-041 Write wstrb=1100, MERGE=0 vs 1 -> two byte beats vs one halfword beat at 0x300 (BIG_ENDIAN=1).
REQ-042 freeahb_next held 0 for 5 cycles during write -> beat outputs stable throughout, no mem_ready.
REQ-043 resetn pulsed low during second beat of a 4-beat write -> outputs at reset values, no mem_ready; next read completes normally.
